fpmul_serial_param: RTL and testbench

- Parametrised successor to the 8-bit nibble-serial FP multiplier.
- Accepts two IEEE-style floats of configurable exponent/mantissa width, loaded MSB-first in NIB_W-bit chunks over a narrow pin interface.
- Multiplies, normalises and handles specials, then presents a parallel result with a valid flag and exception flags.
- Sits behind the chip's io_in/io_out pin mux; the top level serialises `result` onto output pins.

---
 rtl/fpmul_serial_param_if.sv | 24 ++
 rtl/fpmul_serial_param.sv | 218 +++++++++++++++++++++
 tb/tb_fpmul_serial_param.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fpmul_serial_param_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fpmul_serial_param_if                                         |
// | Brief    : Chunk-load and result bus of the serial FP multiplier.        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface fpmul_serial_param_if #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int NIB_W = 4
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             enable;
  logic [NIB_W-1:0] data;
  logic             in_ready;
  logic [W-1:0]     result;
  logic             out_valid;
  logic [3:0]       flags;

  modport master (output enable, data, input in_ready, result, out_valid, flags);
  modport slave  (input enable, data, output in_ready, result, out_valid, flags);
endinterface
`default_nettype wire

// File: rtl/fpmul_serial_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fpmul_serial_param                                            |
// | Brief    : Chunk-serial loaded, parametrised FP multiplier (flush-to-    |
// |            zero). Optional macro FPMUL_RNE_EN selects round-to-nearest-  |
// |            even; otherwise the product is truncated.                     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module fpmul_serial_param #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int NIB_W = 4
) (
  input  wire logic             clock,
  input  wire logic             reset,
  fpmul_serial_param_if.slave   bus
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int BEATS = (W + NIB_W - 1) / NIB_W;
  localparam int SR_W  = BEATS * NIB_W;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam int P_W   = 2 * (MAN_W + 1);
  localparam int E_W   = EXP_W + 2;

  localparam logic [E_W-1:0]   BIAS      = E_W'((2 ** (EXP_W - 1)) - 1);
  localparam logic [E_W-1:0]   EXP_MAX   = E_W'((2 ** EXP_W) - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [2:0] S_LOAD_A = 3'd0;
  localparam logic [2:0] S_LOAD_B = 3'd1;
  localparam logic [2:0] S_MUL    = 3'd2;
  localparam logic [2:0] S_NORM   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic             sign_q, sign_d;
  logic [E_W-1:0]   exp_q, exp_d;
  logic [P_W-1:0]   prod_q, prod_d;
  logic             nan_q, nan_d, inf_q, inf_d, zero_q, zero_d;
  logic [W-1:0]     result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             in_ready;

  always_ff @(posedge clock or negedge reset) begin : p_state_reg
    if (!reset) begin
      state_q  <= S_LOAD_A;
      cnt_q    <= '0;
      sr_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      prod_q   <= '0;
      nan_q    <= 1'b0;
      inf_q    <= 1'b0;
      zero_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      prod_q   <= prod_d;
      nan_q    <= nan_d;
      inf_q    <= inf_d;
      zero_q   <= zero_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  logic            w_accept;
  logic [SR_W-1:0] w_sr_shift;
  logic [SR_W-1:0] w_sr_first;

  assign w_accept   = bus.enable & in_ready;
  // Operand is the low W bits, so surplus high bits of the first chunk fall away.
  assign w_sr_shift = (sr_q << NIB_W) | SR_W'(bus.data);
  assign w_sr_first = SR_W'(bus.data);

  always_comb begin : p_next_state
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      S_LOAD_A, S_LOAD_B: begin
        if (w_accept) begin
          sr_d = w_sr_shift;
          if (cnt_q == LAST_BEAT) begin
            cnt_d = '0;
            if (state_q == S_LOAD_A) begin
              a_d     = W'(w_sr_shift);
              state_d = S_LOAD_B;
            end else begin
              b_d     = W'(w_sr_shift);
              state_d = S_MUL;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_MUL:  state_d = S_NORM;
      S_NORM: state_d = S_DONE;
      S_DONE: begin
        // A chunk taken while the result is shown starts the next A operand.
        if (w_accept) begin
          sr_d = w_sr_first;
          if (BEATS == 1) begin
            a_d     = W'(w_sr_first);
            cnt_d   = '0;
            state_d = S_LOAD_B;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = S_LOAD_A;
          end
        end
      end
      default: state_d = S_LOAD_A;
    endcase
  end

  logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;

  assign {sa, ea, ma} = a_q;
  assign {sb, eb, mb} = b_q;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (ma == '0);
  assign b_inf  = (eb == '1) && (mb == '0);
  assign a_nan  = (ea == '1) && (ma != '0);
  assign b_nan  = (eb == '1) && (mb != '0);

  logic             w_msb, w_guard, w_sticky, w_ovf, w_unf;
  logic [P_W-2:0]   w_norm;
  logic [MAN_W-1:0] w_man;
  logic [MAN_W:0]   w_man_r;
  logic [E_W-1:0]   w_exp_f;

  // Normalised product drops the hidden bit; below it sit mantissa, guard, sticky.
  assign w_msb    = prod_q[P_W-1];
  assign w_norm   = w_msb ? prod_q[P_W-2:0] : {prod_q[P_W-3:0], 1'b0};
  assign w_man    = w_norm[P_W-2 -: MAN_W];
  assign w_guard  = w_norm[MAN_W];
  assign w_sticky = |w_norm[MAN_W-1:0];

`ifdef FPMUL_RNE_EN
  logic w_inc;
  assign w_inc   = w_guard & (w_sticky | w_man[0]);
  assign w_man_r = {1'b0, w_man} + {{MAN_W{1'b0}}, w_inc};
`else
  assign w_man_r = {1'b0, w_man};
`endif

  assign w_exp_f = exp_q + E_W'(w_msb) + E_W'(w_man_r[MAN_W]);
  assign w_ovf   = $signed(w_exp_f) >= $signed(EXP_MAX);
  assign w_unf   = w_exp_f[E_W-1] || (w_exp_f == '0);

  always_comb begin : p_datapath
    sign_d   = sign_q;
    exp_d    = exp_q;
    prod_d   = prod_q;
    nan_d    = nan_q;
    inf_d    = inf_q;
    zero_d   = zero_q;
    result_d = result_q;
    flags_d  = flags_q;
    if (state_q == S_MUL) begin
      sign_d = sa ^ sb;
      exp_d  = E_W'(ea) + E_W'(eb) - BIAS;
      prod_d = P_W'({1'b1, ma}) * P_W'({1'b1, mb});
      nan_d  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
      inf_d  = a_inf | b_inf;
      zero_d = a_zero | b_zero;
    end
    if (state_q == S_NORM) begin
      if (nan_q) begin
        result_d = '1;
        flags_d  = 4'b1000;
      end else if (inf_q) begin
        result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        flags_d  = 4'b0000;
      end else if (zero_q) begin
        result_d = {sign_q, {(W-1){1'b0}}};
        flags_d  = 4'b0000;
      end else if (w_ovf) begin
        result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        flags_d  = 4'b0101;
      end else if (w_unf) begin
        result_d = {sign_q, {(W-1){1'b0}}};
        flags_d  = 4'b0011;
      end else begin
        result_d = {sign_q, w_exp_f[EXP_W-1:0], w_man_r[MAN_W-1:0]};
        flags_d  = {3'b000, w_guard | w_sticky};
      end
    end
  end

  always_comb begin : p_outputs
    in_ready      = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) || (state_q == S_DONE);
    bus.in_ready  = in_ready;
    bus.out_valid = (state_q == S_DONE);
    bus.result    = result_q;
    bus.flags     = flags_q;
  end
endmodule
`default_nettype wire

// File: tb/tb_fpmul_serial_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fpmul_serial_param                                         |
// | Brief    : Scoreboard bench for the 8-bit and 16-bit configurations.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_fpmul_serial_param;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fpmul_serial_param_if #(.EXP_W(4), .MAN_W(3),  .NIB_W(4)) bus8  ();
  fpmul_serial_param_if #(.EXP_W(5), .MAN_W(10), .NIB_W(4)) bus16 ();

  fpmul_serial_param #(.EXP_W(4), .MAN_W(3), .NIB_W(4)) dut8 (
    .clock (clock),
    .reset (reset),
    .bus   (bus8)
  );
  fpmul_serial_param #(.EXP_W(5), .MAN_W(10), .NIB_W(4)) dut16 (
    .clock (clock),
    .reset (reset),
    .bus   (bus16)
  );

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;
    string       name;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;
  int   errors = 0;
  int   checks = 0;
  logic ov8_prev  = 1'b0;
  logic ov16_prev = 1'b0;

`ifdef FPMUL_RNE_EN
  localparam logic [7:0] ROUND_RES = 8'h43;
`else
  localparam logic [7:0] ROUND_RES = 8'h42;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitors: each rising out_valid retires the oldest expected result.
  always @(negedge clock) begin
    if (bus8.out_valid === 1'b1 && !ov8_prev) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid8: result 0x%0h with no pending operation", bus8.result);
      end else begin
        e8 = q8.pop_front();
        check({e8.name, "_result"}, 32'(bus8.result), 32'(e8.res));
        check({e8.name, "_flags"},  32'(bus8.flags),  32'(e8.flg));
      end
    end
    ov8_prev = bus8.out_valid;
  end

  always @(negedge clock) begin
    if (bus16.out_valid === 1'b1 && !ov16_prev) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid16: result 0x%0h with no pending operation", bus16.result);
      end else begin
        e16 = q16.pop_front();
        check({e16.name, "_result"}, 32'(bus16.result), 32'(e16.res));
        check({e16.name, "_flags"},  32'(bus16.flags),  32'(e16.flg));
      end
    end
    ov16_prev = bus16.out_valid;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chunk8(input logic [3:0] d, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      bus8.enable = 1'b0;
      bus8.data   = 4'($urandom);
      tick();
    end
    n = 0;
    while (bus8.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("in_ready8_timeout", 32'(bus8.in_ready), 32'd1);
    bus8.enable = 1'b1;
    bus8.data   = d;
    tick();
    bus8.enable = 1'b0;
  endtask

  task automatic chunk16(input logic [3:0] d);
    int n;
    n = 0;
    while (bus16.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("in_ready16_timeout", 32'(bus16.in_ready), 32'd1);
    bus16.enable = 1'b1;
    bus16.data   = d;
    tick();
    bus16.enable = 1'b0;
  endtask

  // Result appears exactly two edges after the edge taking the last B chunk.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] res,
                     input logic [3:0] flg, input string name, input int gap);
    exp_t e;
    e.res = 16'(res);
    e.flg = flg;
    e.name = name;
    q8.push_back(e);
    chunk8(a[7:4], gap);
    chunk8(a[3:0], gap);
    chunk8(b[7:4], gap);
    chunk8(b[3:0], gap);
    check({name, "_lat0"}, 32'(bus8.out_valid), 32'd0);
    tick();
    check({name, "_lat1"}, 32'(bus8.out_valid), 32'd0);
    tick();
    check({name, "_lat2"}, 32'(bus8.out_valid), 32'd1);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic [15:0] res,
                      input logic [3:0] flg, input string name);
    exp_t e;
    e.res = res;
    e.flg = flg;
    e.name = name;
    q16.push_back(e);
    for (int i = 3; i >= 0; i--) chunk16(a[i*4 +: 4]);
    for (int i = 3; i >= 0; i--) chunk16(b[i*4 +: 4]);
    tick();
    tick();
    check({name, "_valid"}, 32'(bus16.out_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    bus8.enable  = 1'b0;
    bus8.data    = '0;
    bus16.enable = 1'b0;
    bus16.data   = '0;
    reset        = 1'b0;
    tick();
    tick();
    check("rst_out_valid8", 32'(bus8.out_valid),  32'd0);
    check("rst_in_ready8", 32'(bus8.in_ready),    32'd1);
    check("rst_result8",   32'(bus8.result),      32'd0);
    check("rst_flags8",    32'(bus8.flags),       32'd0);
    check("rst_out_valid16", 32'(bus16.out_valid), 32'd0);
    check("rst_result16",  32'(bus16.result),     32'd0);
    reset = 1'b1;
    tick();

    op8(8'h77, 8'h77, 8'h78, 4'b0101, "overflow", 0);
    op8(8'hD2, 8'h44, 8'hDF, 4'b0000, "neg30", 0);
    op8(8'hFA, 8'h78, 8'hFF, 4'b1000, "nan_x_inf", 0);
    op8(8'h78, 8'h00, 8'hFF, 4'b1000, "inf_x_zero", 0);
    op8(8'h3D, 8'h3D, ROUND_RES, 4'b0001, "round", 0);
    op8(8'hF8, 8'h44, 8'hF8, 4'b0000, "ninf_x_fin", 0);
    op8(8'h05, 8'hC4, 8'h80, 4'b0000, "ftz_neg_zero", 0);
    op8(8'h08, 8'h08, 8'h00, 4'b0011, "underflow8", 0);
    op8(8'hD2, 8'h44, 8'hDF, 4'b0000, "stalled", 1);

    // Abort after three chunks; the next four chunks must form a fresh pair.
    chunk8(4'hD, 0);
    chunk8(4'h2, 0);
    chunk8(4'h4, 0);
    #2 reset = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus8.out_valid), 32'd0);
    check("abort_in_ready",  32'(bus8.in_ready),  32'd1);
    check("abort_result",    32'(bus8.result),    32'd0);
    tick();
    reset = 1'b1;
    tick();
    op8(8'h77, 8'h77, 8'h78, 4'b0101, "after_abort", 0);

    op16(16'h3C00, 16'hC000, 16'hC000, 4'b0000, "one_x_neg2");
    op16(16'h0400, 16'h0400, 16'h0000, 4'b0011, "underflow16");

    n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("drain_timeout", 32'(q8.size() + q16.size()), 32'd0);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
